// File: rtl/iomem_decoder.sv
// iomem_decoder: address decoder and response multiplexer for the PicoSOC
// iomem bus. It routes the CPU request to one of four peripherals, returns
// that peripheral's ready/rdata, and answers unmapped or stalled accesses
// with an error response.
//
// Handshake: the CPU raises iomem_valid and holds it, with a stable address,
// until it sees iomem_ready, which this block pulses for exactly one cycle.
// Each slave sees s_iomem_valid[n] high until it answers with s_iomem_ready[n]
// or until the timeout expires. s_iomem_valid drops on the same edge that
// samples the ready, so a slave never sees a second access by mistake.
module iomem_decoder #(
  parameter logic [7:0]  REGION    = 8'h03,
  parameter int unsigned SEL_LSB   = 8,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         iomem_valid,
  output logic         iomem_ready,
  input  logic [31:0]  iomem_addr,
  output logic [31:0]  iomem_rdata,
  output logic [3:0]   s_iomem_valid,
  input  logic [3:0]   s_iomem_ready,
  input  logic [127:0] s_iomem_rdata,
  output logic         bus_err,
  output logic [1:0]   dbg_state
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Last counter value before the wait for the slave is abandoned
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  svalid_q, svalid_d;
  logic        err_q, err_d;

  // Address decode: the top byte selects the IO region, the two bits at
  // SEL_LSB pick the slave, and every bit between them must be zero.
  logic        region_hit;
  logic        window_hit;
  logic        mapped;
  logic [1:0]  sel;
  logic [23:0] above_sel;

  assign above_sel  = iomem_addr[23:0] >> (SEL_LSB + 2);
  assign region_hit = (iomem_addr[31:24] == REGION);
  assign window_hit = (above_sel == 24'd0);
  assign mapped     = region_hit && window_hit;
  assign sel        = 2'(iomem_addr >> SEL_LSB);

  // Response of the slave latched at request time; other slaves are ignored
  logic        sel_ready;
  logic [31:0] sel_rdata;

  assign sel_ready = s_iomem_ready[idx_q];
  assign sel_rdata = s_iomem_rdata[{idx_q, 5'd0} +: 32];

  // Next-state logic for the request/wait/response sequence
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    svalid_d = svalid_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iomem_valid) begin
          if (mapped) begin
            idx_d    = sel;
            svalid_d = 4'b0001 << sel;
            cnt_d    = 16'd0;
            state_d  = ST_BUSY;
          end else begin
            rdata_d = ERR_RDATA;
            ready_d = 1'b1;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_BUSY: begin
        // A ready on the final timeout cycle still counts as a normal answer
        if (sel_ready) begin
          rdata_d  = sel_rdata;
          ready_d  = 1'b1;
          svalid_d = 4'b0000;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d  = ERR_RDATA;
          ready_d  = 1'b1;
          err_d    = 1'b1;
          svalid_d = 4'b0000;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_RESP: begin
        // The CPU drops valid on the ready edge, so nothing is accepted here
        state_d = ST_IDLE;
      end

      default: begin
        svalid_d = 4'b0000;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State registers; reset also aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= 16'd0;
      ready_q  <= 1'b0;
      rdata_q  <= 32'd0;
      svalid_q <= 4'b0000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      svalid_q <= svalid_d;
      err_q    <= err_d;
    end
  end

  assign iomem_ready   = ready_q;
  assign iomem_rdata   = rdata_q;
  assign s_iomem_valid = svalid_q;
  assign bus_err       = err_q;
  assign dbg_state     = state_q;

  // Bus invariants
  a_svalid_onehot0: assert property (@(posedge clk) disable iff (!resetn)
    $onehot0(s_iomem_valid));
  a_ready_single: assert property (@(posedge clk) disable iff (!resetn)
    iomem_ready |=> !iomem_ready);
  a_err_with_ready: assert property (@(posedge clk) disable iff (!resetn)
    bus_err |-> iomem_ready);

endmodule

// File: tb/tb_iomem_decoder.sv
// Testbench for iomem_decoder: a CPU driver and four slave models on the
// falling edge, a monitor just after the rising edge that compares every
// response against an expected queue filled by the driver.
module tb_iomem_decoder;

  localparam int          TO      = 4;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;
  localparam int          NEVER   = 1000;
  // expected entry: {bus_err, rdata, latency, s_valid high cycles}
  localparam int          W       = 49;

  logic         clk;
  logic         resetn;
  logic         iomem_valid;
  logic         iomem_ready;
  logic [31:0]  iomem_addr;
  logic [31:0]  iomem_rdata;
  logic [3:0]   s_iomem_valid;
  logic [3:0]   s_iomem_ready;
  logic [127:0] s_iomem_rdata;
  logic         bus_err;
  logic [1:0]   dbg_state;

  iomem_decoder #(
    .REGION   (8'h03),
    .SEL_LSB  (8),
    .TIMEOUT  (TO),
    .ERR_RDATA(ERR_VAL)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .iomem_valid  (iomem_valid),
    .iomem_ready  (iomem_ready),
    .iomem_addr   (iomem_addr),
    .iomem_rdata  (iomem_rdata),
    .s_iomem_valid(s_iomem_valid),
    .s_iomem_ready(s_iomem_ready),
    .s_iomem_rdata(s_iomem_rdata),
    .bus_err      (bus_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // Shared driver/monitor context
  int          tgt = -1;
  int          slv_lat[4];
  int          scnt[4];
  logic [31:0] slv_rdata[4];
  logic        foreign = 1'b0;
  logic [3:0]  exp_mask = 4'b0000;
  int unsigned req_cyc = 0;

  assign s_iomem_rdata = {slv_rdata[3], slv_rdata[2], slv_rdata[1], slv_rdata[0]};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- slave models ----------------
  // The target answers L cycles after it first sees its valid (registered
  // slave style); the others optionally raise spurious ready.
  initial begin
    s_iomem_ready = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      slv_lat[n]   = NEVER;
      scnt[n]      = 0;
      slv_rdata[n] = 32'd0;
    end
    forever begin
      @(negedge clk);
      for (int n = 0; n < 4; n++) begin
        if (n == tgt && s_iomem_valid[n]) begin
          scnt[n]++;
          s_iomem_ready[n] = (scnt[n] > slv_lat[n]);
        end else if (n == tgt) begin
          scnt[n] = 0;
          s_iomem_ready[n] = 1'b0;
        end else begin
          scnt[n] = 0;
          s_iomem_ready[n] = foreign ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
  end

  // ---------------- CPU driver ----------------
  task automatic issue(input logic [31:0] addr, input int lat, input bit fgn,
                       input bit drop_early, input logic [31:0] rd_val);
    bit          is_mapped;
    int          idx;
    logic        e_err;
    logic [31:0] e_rd;
    logic [7:0]  e_lat;
    logic [7:0]  e_sv;
    bit          seen;
    // Slave n owns 0x0300_0000 + n*0x100 .. +0xFF
    is_mapped = (addr >= 32'h0300_0000) && (addr < 32'h0300_0400);
    idx       = is_mapped ? int'((addr - 32'h0300_0000) / 256) : -1;
    for (int n = 0; n < 4; n++) slv_rdata[n] = $urandom;
    if (is_mapped && rd_val != 32'd0) slv_rdata[idx] = rd_val;
    tgt = idx;
    if (is_mapped) slv_lat[idx] = lat;
    if (!is_mapped) begin
      e_err = 1'b1; e_rd = ERR_VAL; e_lat = 8'd1; e_sv = 8'd0;
      exp_mask = 4'b0000;
    end else if (lat < TO) begin
      e_err = 1'b0; e_rd = slv_rdata[idx]; e_lat = 8'(lat + 2); e_sv = 8'(lat + 1);
      exp_mask = 4'b0001 << idx;
    end else begin
      e_err = 1'b1; e_rd = ERR_VAL; e_lat = 8'(TO + 1); e_sv = 8'(TO);
      exp_mask = 4'b0001 << idx;
    end
    exp_q.push_back({e_err, e_rd, e_lat, e_sv});
    foreign     = fgn;
    req_cyc     = cyc;
    iomem_addr  = addr;
    iomem_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (iomem_ready) begin
        seen = 1'b1;
        break;
      end
      if (drop_early) iomem_valid = 1'b0;
    end
    iomem_valid = 1'b0;
    foreign     = 1'b0;
    chk("response_seen", {63'd0, seen}, 64'd1);
    @(negedge clk);
  endtask

  // Reset pulse while a slave is stalled in BUSY: no response may follow
  task automatic abort_busy();
    for (int n = 0; n < 4; n++) slv_rdata[n] = $urandom;
    tgt         = 3;
    slv_lat[3]  = NEVER;
    exp_mask    = 4'b1000;
    iomem_addr  = 32'h0300_0300;
    iomem_valid = 1'b1;
    repeat (2) @(negedge clk);
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [31:0]  last_rd;
    logic         prev_ready;
    int unsigned  sv_cnt;
    logic [W-1:0] e;
    last_rd    = 32'd0;
    prev_ready = 1'b0;
    sv_cnt     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        chk("reset_outputs", {26'd0, iomem_ready, iomem_rdata, s_iomem_valid, bus_err}, 64'd0);
        chk("reset_state", {62'd0, dbg_state}, 64'd0);
        last_rd    = 32'd0;
        prev_ready = 1'b0;
        sv_cnt     = 0;
      end else begin
        chk("svalid_select",
            {63'd0, ($countones(s_iomem_valid) > 1) || ((s_iomem_valid & ~exp_mask) != 4'b0000)},
            64'd0);
        if (s_iomem_valid != 4'b0000) sv_cnt++;
        chk("ready_not_consecutive", {63'd0, iomem_ready && prev_ready}, 64'd0);
        if (iomem_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: got ready=1 expected no response (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            chk("bus_err", {63'd0, bus_err}, {63'd0, e[48]});
            chk("rdata", {32'd0, iomem_rdata}, {32'd0, e[47:16]});
            chk("latency", {32'd0, cyc - req_cyc}, {56'd0, e[15:8]});
            chk("svalid_cycles", {32'd0, sv_cnt}, {56'd0, e[7:0]});
          end
          last_rd = iomem_rdata;
          sv_cnt  = 0;
        end else begin
          chk("err_without_ready", {63'd0, bus_err}, 64'd0);
          chk("rdata_hold", {32'd0, iomem_rdata}, {32'd0, last_rd});
        end
        prev_ready = iomem_ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    int          n;
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_addr  = 32'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // directed cases
    issue(32'h0300_0000, 1, 0, 0, 32'h0000_0001);
    issue(32'h0300_0200, 1, 0, 0, 32'h0000_00A5);
    issue(32'h0300_1000, 0, 0, 0, 32'd0);
    issue(32'h0400_0000, 0, 0, 0, 32'd0);
    issue(32'h0300_0300, NEVER, 0, 0, 32'd0);
    issue(32'h0300_0100, TO - 1, 0, 0, 32'd0);
    issue(32'h0300_0100, TO, 0, 0, 32'd0);
    issue(32'h0300_0200, 2, 1, 0, 32'd0);
    issue(32'h0300_0300, NEVER, 1, 0, 32'd0);
    abort_busy();
    issue(32'h0300_0000, 1, 0, 0, 32'd0);
    issue(32'h0300_0000, 0, 0, 0, 32'd0);
    issue(32'h0300_0100, 0, 0, 0, 32'd0);
    issue(32'h0300_0304, 2, 0, 1, 32'd0);
    issue(32'h0300_00FC, 0, 0, 0, 32'd0);
    issue(32'h0300_0400, 0, 0, 0, 32'd0);
    issue(32'h02FF_FFFF, 0, 0, 0, 32'd0);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0, 1: a = 32'h0300_0000 + 32'(n * 256) + 32'($urandom_range(0, 255));
        2:    a = 32'h0300_0000 + 32'($urandom_range(1, 16383) * 1024) + 32'($urandom_range(0, 1023));
        3:    a = {8'($urandom_range(0, 255)), 24'($urandom_range(0, 1023))};
        default: a = $urandom;
      endcase
      issue(a, $urandom_range(0, TO + 2), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 32'd0);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
